// File: rtl/hpc_csr_bank.sv
// Avalon-MM control/status register bank for the HPC bridge, with byte enables and an error counter.
// Define HPC_SNAPSHOT_EN to make a read of the first status word latch a coherent copy of all status words.
module hpc_csr_bank #(
    parameter int          SYS_VERSION = 20,
    parameter int          NUM_CTRL    = 2,
    parameter int          NUM_STAT    = 4,
    parameter int          ADDR_W      = 6,
    parameter logic [31:0] PULSE_MASK  = 32'h0000_0001
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        slave_address,
    input  logic                     slave_read,
    input  logic                     slave_write,
    input  logic [3:0]               slave_byteenable,
    input  logic [31:0]              slave_writedata,
    output logic [31:0]              slave_readdata,
    output logic                     slave_readdatavalid,
    output logic [NUM_CTRL*32-1:0]   o_ctrl,
    input  logic [NUM_STAT*32-1:0]   i_stat
);
    localparam logic [31:0] STAT_BASE = 32'(NUM_CTRL);
    localparam logic [31:0] VER_IDX   = 32'(NUM_CTRL + NUM_STAT);
    localparam logic [31:0] ERR_IDX   = 32'(NUM_CTRL + NUM_STAT + 1);

    logic [31:0] idx;
    logic        rd_acc;
    logic        wr_acc;
    logic        err;
    logic        cnt_clr;
    logic [31:0] lane_mask;
    logic        addr_lsb_unused;

    logic [31:0] ctrl_q [NUM_CTRL];
    logic [31:0] ctrl_d [NUM_CTRL];
    logic [31:0] stat_rd [NUM_STAT];
    logic [31:0] readdata_q, readdata_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    assign idx             = 32'(slave_address[ADDR_W-1:2]);
    assign addr_lsb_unused = ^slave_address[1:0];
    assign rd_acc          = slave_read & ~slave_write;
    assign wr_acc          = slave_write & ~slave_read;
    assign lane_mask       = {{8{slave_byteenable[3]}}, {8{slave_byteenable[2]}},
                              {8{slave_byteenable[1]}}, {8{slave_byteenable[0]}}};
    assign cnt_clr         = wr_acc && (idx == ERR_IDX);

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign o_ctrl[32*g +: 32] = ctrl_q[g];
    end

`ifdef HPC_SNAPSHOT_EN
    logic [31:0] shadow_q [NUM_STAT];
    logic [31:0] shadow_d [NUM_STAT];

    // Reading the first status word freezes every status word for the follow-up reads.
    always_comb begin
        for (int s = 0; s < NUM_STAT; s++) begin
            shadow_d[s] = shadow_q[s];
            stat_rd[s]  = (s == 0) ? i_stat[31:0] : shadow_q[s];
        end
        if (rd_acc && idx == STAT_BASE) begin
            for (int s = 0; s < NUM_STAT; s++) begin
                shadow_d[s] = i_stat[32*s +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_STAT; s++) begin
                shadow_q[s] <= 32'h0;
            end
        end else begin
            for (int s = 0; s < NUM_STAT; s++) begin
                shadow_q[s] <= shadow_d[s];
            end
        end
    end
`else
    always_comb begin
        for (int s = 0; s < NUM_STAT; s++) begin
            stat_rd[s] = i_stat[32*s +: 32];
        end
    end
`endif

    // Pulse bits drop every cycle unless this cycle's write sets them again.
    always_comb begin
        for (int k = 0; k < NUM_CTRL; k++) begin
            ctrl_d[k] = ctrl_q[k];
        end
        ctrl_d[0] = ctrl_q[0] & ~PULSE_MASK;
        if (wr_acc) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (idx == 32'(k)) begin
                    ctrl_d[k] = (ctrl_d[k] & ~lane_mask) | (slave_writedata & lane_mask);
                end
            end
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        valid_d    = rd_acc;
        if (rd_acc) begin
            readdata_d = 32'h0;
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (idx == 32'(k)) readdata_d = ctrl_q[k];
            end
            for (int s = 0; s < NUM_STAT; s++) begin
                if (idx == STAT_BASE + 32'(s)) readdata_d = stat_rd[s];
            end
            if (idx == VER_IDX) readdata_d = 32'(SYS_VERSION);
            if (idx == ERR_IDX) readdata_d = {16'h0, cnt_q};
        end
    end

    always_comb begin
        err = slave_read & slave_write;
        if (wr_acc && idx >= STAT_BASE && idx != ERR_IDX) err = 1'b1;
        if (rd_acc && idx > ERR_IDX) err = 1'b1;
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = err ? 16'h1 : 16'h0;
        end else if (err && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'h1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= 32'h0;
            end
            readdata_q <= 32'h0;
            valid_q    <= 1'b0;
            cnt_q      <= 16'h0;
        end else begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= ctrl_d[k];
            end
            readdata_q <= readdata_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign slave_readdata      = readdata_q;
    assign slave_readdatavalid = valid_q;
endmodule
